// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and width limits.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single combinational full-adder cell shared by every bit position of the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock through one fa_cell.
// start/busy/done handshake; sum, cout and ovf are held between completions.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_co;
    logic             w_accept;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    fa_cell u_fa (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_BIT);
    assign w_res_nxt = {w_s, r_res};

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE for back-to-back use.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so busy/done can be registered without extra latency.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            SHIFT:   w_busy_nxt = 1'b1;
            DONE:    w_done_nxt = 1'b1;
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Serial datapath; on the last bit r_carry still holds the carry into the MSB.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= sub;
        end else if (r_state == SHIFT) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_res   <= w_res_nxt[WIDTH-1:1];
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_co;
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_co;
                r_ovf  <= w_co ^ r_carry;
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_res   <= r_res;
            r_cnt   <= r_cnt;
            r_carry <= r_carry;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
